// File: rtl/nn_data_path.sv
// -----------------------------------------------------------------------------
// nn_data_path
// Training datapath for a small fixed-point dense network. Four register-file
// storages (code, weight, input, label) feed a microcoded controller. A matrix
// locator walks the rows of the selected layer and issues (x, w, z, label)
// tuples through an output register to the activation/derivative stage.
// Each 48-bit word holds three signed Q8.8 lanes: [47:32], [31:16], [15:0].
//
// Configuration macro: SATURATE_EN
//   defined   -> weight update and z product saturate per lane (7FFF/8000)
//   undefined -> both wrap modulo 2^16
//
// Ports (summary):
//   clk_clk, reset_reset_n (sync, active-high), activate_to_diff_register_clock_clk
//   code_storage_*        : code line write, code read enable
//   controller_enable_*   : controller run enable
//   weight_storage_*      : weight write and weight update (w -= dc_dw)
//   input_storage_*, label_storage_* : row writes
//   matrix_storage_locator_reset_interface_reset : restart pc/row/layer
//   controller_use_z_interface_use_z : x currently sourced from the z buffer
//   activate_to_diff_register_out_* : registered output tuple
// -----------------------------------------------------------------------------
module nn_data_path #(
  parameter int LAYERS     = 4,
  parameter int ROWS       = 4,
  parameter int CODE_DEPTH = 16
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        activate_to_diff_register_clock_clk,
  input  logic        code_storage_write_interface_is_write,
  input  logic [31:0] code_storage_write_interface_write_line,
  input  logic [11:0] code_storage_write_interface_write_data,
  input  logic        code_storage_enable_interface_enable,
  input  logic        controller_enable_interface_enable,
  input  logic        weight_storage_is_write_interface_is_write,
  input  logic [31:0] weight_storage_write_interface_write_layer_index,
  input  logic [31:0] weight_storage_write_interface_write_row_index,
  input  logic [47:0] weight_storage_write_interface_write_data,
  input  logic        weight_storage_is_update_interface_is_update,
  input  logic [31:0] weight_storage_update_weight_interface_layer_index,
  input  logic [31:0] weight_storage_update_weight_interface_row_index,
  input  logic [47:0] weight_storage_update_weight_interface_dc_dw,
  input  logic        input_storage_is_write_interface_is_write,
  input  logic [31:0] input_storage_write_interface_write_layer_index,
  input  logic [31:0] input_storage_write_interface_write_row_index,
  input  logic [47:0] input_storage_write_interface_write_data,
  input  logic        label_storage_is_write_interface_is_write,
  input  logic [31:0] label_storage_write_interface_write_layer_index,
  input  logic [31:0] label_storage_write_interface_write_row_index,
  input  logic [47:0] label_storage_write_interface_write_data,
  input  logic        matrix_storage_locator_reset_interface_reset,
  output logic        controller_use_z_interface_use_z,
  output logic [47:0] activate_to_diff_register_out_x_interface_x,
  output logic [47:0] activate_to_diff_register_out_w_interface_w,
  output logic [47:0] activate_to_diff_register_out_z_interface_z,
  output logic [47:0] activate_to_diff_register_out_forward_interface_label,
  output logic [31:0] activate_to_diff_register_out_forward_interface_w_layer_index,
  output logic [31:0] activate_to_diff_register_out_forward_interface_w_row_index,
  output logic [3:0]  activate_to_diff_register_out_forward_interface_dense_type,
  output logic        activate_to_diff_register_out_forward_interface_is_update,
  output logic        activate_to_diff_register_out_forward_interface_backprop_cost,
  output logic [7:0]  activate_to_diff_register_out_cost_type_interface_cost_type
);

  localparam int CW = $clog2(CODE_DEPTH);
  localparam int LW = $clog2(LAYERS);
  localparam int RW = $clog2(ROWS);
  localparam int AW = $clog2(LAYERS * ROWS);
  localparam logic [31:0] LAYERS_U = 32'(LAYERS);
  localparam logic [31:0] ROWS_U   = 32'(ROWS);
  localparam logic [31:0] DEPTH_U  = 32'(CODE_DEPTH);

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_FWD = 2'b01;
  localparam logic [1:0] OP_BP  = 2'b10;
  localparam logic [1:0] OP_END = 2'b11;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FETCH = 2'd1, S_EXEC = 2'd2, S_DONE = 2'd3} state_t;

  // Flat (layer, row) address; both indices wrap at their depth.
  function automatic logic [AW-1:0] mem_addr(input logic [31:0] l, input logic [31:0] r);
    logic [31:0] a;
    a = (l % LAYERS_U) * ROWS_U + (r % ROWS_U);
    return a[AW-1:0];
  endfunction

  function automatic logic [CW-1:0] code_idx(input logic [31:0] line);
    logic [31:0] a;
    a = line % DEPTH_U;
    return a[CW-1:0];
  endfunction

  function automatic logic [LW-1:0] layer_idx(input logic [1:0] l);
    logic [31:0] a;
    a = {30'd0, l} % LAYERS_U;
    return a[LW-1:0];
  endfunction

  // One Q8.8 lane: (a*b) >>> 8, keeping the low 16 bits or clamping.
  function automatic logic [15:0] mul_lane(input logic [15:0] a, input logic [15:0] b);
    logic signed [31:0] ae;
    logic signed [31:0] be;
`ifdef SATURATE_EN
    logic signed [31:0] p;
    ae = {{16{a[15]}}, a};
    be = {{16{b[15]}}, b};
    p  = ae * be;
    if (p > 32'sh007F_FFFF) begin
      return 16'h7FFF;
    end else if (p < -32'sh0080_0000) begin
      return 16'h8000;
    end else begin
      return 16'(p >>> 8);
    end
`else
    ae = {{16{a[15]}}, a};
    be = {{16{b[15]}}, b};
    return 16'((ae * be) >>> 8);
`endif
  endfunction

  // One lane of the weight update a - b.
  function automatic logic [15:0] sub_lane(input logic [15:0] a, input logic [15:0] b);
`ifdef SATURATE_EN
    logic signed [16:0] d;
    d = $signed({a[15], a}) - $signed({b[15], b});
    if (d > 17'sd32767) begin
      return 16'h7FFF;
    end else if (d < -17'sd32768) begin
      return 16'h8000;
    end else begin
      return d[15:0];
    end
`else
    return a - b;
`endif
  endfunction

  function automatic logic [47:0] mul_word(input logic [47:0] x, input logic [47:0] w);
    logic [47:0] r;
    r = 48'd0;
    for (int i = 0; i < 3; i++) r[16*i +: 16] = mul_lane(x[16*i +: 16], w[16*i +: 16]);
    return r;
  endfunction

  function automatic logic [47:0] sub_word(input logic [47:0] a, input logic [47:0] b);
    logic [47:0] r;
    r = 48'd0;
    for (int i = 0; i < 3; i++) r[16*i +: 16] = sub_lane(a[16*i +: 16], b[16*i +: 16]);
    return r;
  endfunction

  logic [11:0] code_mem_r   [CODE_DEPTH];
  logic [47:0] weight_mem_r [LAYERS*ROWS];
  logic [47:0] input_mem_r  [LAYERS*ROWS];
  logic [47:0] label_mem_r  [LAYERS*ROWS];
  logic [47:0] z_buf_r      [ROWS];

  state_t        state_r;
  logic [CW-1:0] pc_r;
  logic [RW-1:0] row_r;
  logic [1:0]    op_r;
  logic [3:0]    dense_r;
  logic [1:0]    cost_r;
  logic [LW-1:0] layer_r;

  logic [47:0] out_x_r, out_w_r, out_z_r, out_label_r;
  logic [31:0] out_layer_r, out_row_r;
  logic [3:0]  out_dense_r;
  logic        out_is_update_r, out_bp_cost_r;
  logic [7:0]  out_cost_r;

  logic          run_s, exec_fire_s, use_z_s, last_row_s;
  logic [11:0]   code_word_s;
  logic [CW-1:0] pc_next_s;
  logic [AW-1:0] exec_addr_s;
  logic [47:0]   x_s, w_s, z_s;
  logic          unused_s;

  assign run_s       = code_storage_enable_interface_enable & controller_enable_interface_enable;
  assign code_word_s = code_mem_r[pc_r];
  assign pc_next_s   = (pc_r == CW'(CODE_DEPTH - 1)) ? {CW{1'b0}} : pc_r + CW'(1);
  assign last_row_s  = (row_r == RW'(ROWS - 1));
  assign use_z_s     = (state_r == S_EXEC) && (op_r == OP_FWD) && (layer_r != {LW{1'b0}});
  // An EXEC row only commits when nothing higher-priority overrides this cycle.
  assign exec_fire_s = (state_r == S_EXEC) && run_s && !reset_reset_n
                       && !matrix_storage_locator_reset_interface_reset;
  assign exec_addr_s = mem_addr(32'(layer_r), 32'(row_r));
  assign w_s         = weight_mem_r[exec_addr_s];
  assign x_s         = use_z_s ? z_buf_r[row_r] : input_mem_r[exec_addr_s];
  assign z_s         = mul_word(x_s, w_s);
  assign unused_s    = ^{activate_to_diff_register_clock_clk, code_word_s[3:2]};

  // Code storage write port.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n && code_storage_write_interface_is_write) begin
      code_mem_r[code_idx(code_storage_write_interface_write_line)] <= code_storage_write_interface_write_data;
    end
  end

  // Weight storage: update then write, so a same-address write lands last and wins.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n && weight_storage_is_update_interface_is_update) begin
      weight_mem_r[mem_addr(weight_storage_update_weight_interface_layer_index,
                            weight_storage_update_weight_interface_row_index)] <=
        sub_word(weight_mem_r[mem_addr(weight_storage_update_weight_interface_layer_index,
                                       weight_storage_update_weight_interface_row_index)],
                 weight_storage_update_weight_interface_dc_dw);
    end
    if (!reset_reset_n && weight_storage_is_write_interface_is_write) begin
      weight_mem_r[mem_addr(weight_storage_write_interface_write_layer_index,
                            weight_storage_write_interface_write_row_index)] <=
        weight_storage_write_interface_write_data;
    end
  end

  // Input and label storage write ports.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n && input_storage_is_write_interface_is_write) begin
      input_mem_r[mem_addr(input_storage_write_interface_write_layer_index,
                           input_storage_write_interface_write_row_index)] <= input_storage_write_interface_write_data;
    end
    if (!reset_reset_n && label_storage_is_write_interface_is_write) begin
      label_mem_r[mem_addr(label_storage_write_interface_write_layer_index,
                           label_storage_write_interface_write_row_index)] <= label_storage_write_interface_write_data;
    end
  end

  // FORWARD rows leave their z behind for the next layer to consume.
  always_ff @(posedge clk_clk) begin
    if (exec_fire_s && (op_r == OP_FWD)) begin
      z_buf_r[row_r] <= z_s;
    end
  end

  // Controller FSM, matrix locator and output register.
  always_ff @(posedge clk_clk) begin
    if (reset_reset_n) begin
      state_r         <= S_IDLE;
      pc_r            <= {CW{1'b0}};
      row_r           <= {RW{1'b0}};
      op_r            <= OP_NOP;
      dense_r         <= 4'd0;
      cost_r          <= 2'd0;
      layer_r         <= {LW{1'b0}};
      out_x_r         <= 48'd0;
      out_w_r         <= 48'd0;
      out_z_r         <= 48'd0;
      out_label_r     <= 48'd0;
      out_layer_r     <= 32'd0;
      out_row_r       <= 32'd0;
      out_dense_r     <= 4'd0;
      out_is_update_r <= 1'b0;
      out_bp_cost_r   <= 1'b0;
      out_cost_r      <= 8'd0;
    end else if (matrix_storage_locator_reset_interface_reset) begin
      state_r         <= S_IDLE;
      pc_r            <= {CW{1'b0}};
      row_r           <= {RW{1'b0}};
      out_is_update_r <= 1'b0;
      out_bp_cost_r   <= 1'b0;
    end else if (run_s) begin
      case (state_r)
        S_IDLE: begin
          state_r         <= S_FETCH;
          out_is_update_r <= 1'b0;
          out_bp_cost_r   <= 1'b0;
        end
        S_FETCH: begin
          out_is_update_r <= 1'b0;
          out_bp_cost_r   <= 1'b0;
          op_r            <= code_word_s[11:10];
          dense_r         <= code_word_s[9:6];
          cost_r          <= code_word_s[5:4];
          layer_r         <= layer_idx(code_word_s[1:0]);
          case (code_word_s[11:10])
            OP_NOP:  pc_r <= pc_next_s;
            OP_END:  state_r <= S_DONE;
            default: begin
              state_r <= S_EXEC;
              row_r   <= {RW{1'b0}};
            end
          endcase
        end
        S_EXEC: begin
          out_x_r         <= x_s;
          out_w_r         <= w_s;
          out_z_r         <= z_s;
          out_label_r     <= label_mem_r[exec_addr_s];
          out_layer_r     <= 32'(layer_r);
          out_row_r       <= 32'(row_r);
          out_dense_r     <= dense_r;
          out_cost_r      <= {6'd0, cost_r};
          out_is_update_r <= (op_r == OP_BP);
          out_bp_cost_r   <= (op_r == OP_BP) && last_row_s;
          if (last_row_s) begin
            row_r   <= {RW{1'b0}};
            pc_r    <= pc_next_s;
            state_r <= S_FETCH;
          end else begin
            row_r <= row_r + RW'(1);
          end
        end
        S_DONE: begin
          out_is_update_r <= 1'b0;
          out_bp_cost_r   <= 1'b0;
        end
        default: begin
          state_r         <= S_IDLE;
          out_is_update_r <= 1'b0;
          out_bp_cost_r   <= 1'b0;
        end
      endcase
    end else begin
      state_r <= state_r;
    end
  end

  assign controller_use_z_interface_use_z                              = use_z_s;
  assign activate_to_diff_register_out_x_interface_x                   = out_x_r;
  assign activate_to_diff_register_out_w_interface_w                   = out_w_r;
  assign activate_to_diff_register_out_z_interface_z                   = out_z_r;
  assign activate_to_diff_register_out_forward_interface_label         = out_label_r;
  assign activate_to_diff_register_out_forward_interface_w_layer_index = out_layer_r;
  assign activate_to_diff_register_out_forward_interface_w_row_index   = out_row_r;
  assign activate_to_diff_register_out_forward_interface_dense_type    = out_dense_r;
  assign activate_to_diff_register_out_forward_interface_is_update     = out_is_update_r;
  assign activate_to_diff_register_out_forward_interface_backprop_cost = out_bp_cost_r;
  assign activate_to_diff_register_out_cost_type_interface_cost_type   = out_cost_r;

endmodule

// File: tb/tb_nn_data_path.sv
module tb_nn_data_path;

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_FWD = 2'b01;
  localparam logic [1:0] OP_BP  = 2'b10;
  localparam logic [1:0] OP_END = 2'b11;

  typedef struct packed {
    logic [47:0] x;
    logic [47:0] w;
    logic [47:0] z;
    logic [47:0] label;
    logic [31:0] layer;
    logic [31:0] row;
    logic [3:0]  dense;
    logic        is_update;
    logic        bp_cost;
    logic [7:0]  cost;
  } out_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, code_we, code_en, ctrl_en, loc_rst;
  logic [31:0] code_line;
  logic [11:0] code_data;
  logic        w_we, w_upd, in_we, lab_we;
  logic [31:0] w_l, w_r, u_l, u_r, in_l, in_r, lab_l, lab_r;
  logic [47:0] w_d, u_d, in_d, lab_d;

  logic        use_z;
  logic [47:0] dut_x, dut_w, dut_z, dut_label;
  logic [31:0] dut_layer, dut_row;
  logic [3:0]  dut_dense;
  logic        dut_is_update, dut_bp_cost;
  logic [7:0]  dut_cost;

  int n_vec = 0;
  int n_err = 0;

  out_t sb[$];
  logic uz_q[$];
  logic [47:0] m_weight[4][4];
  logic [47:0] m_input[4][4];
  logic [47:0] m_label[4][4];
  logic [47:0] m_zbuf[4];

  nn_data_path dut (
    .clk_clk(clk),
    .reset_reset_n(reset),
    .activate_to_diff_register_clock_clk(clk),
    .code_storage_write_interface_is_write(code_we),
    .code_storage_write_interface_write_line(code_line),
    .code_storage_write_interface_write_data(code_data),
    .code_storage_enable_interface_enable(code_en),
    .controller_enable_interface_enable(ctrl_en),
    .weight_storage_is_write_interface_is_write(w_we),
    .weight_storage_write_interface_write_layer_index(w_l),
    .weight_storage_write_interface_write_row_index(w_r),
    .weight_storage_write_interface_write_data(w_d),
    .weight_storage_is_update_interface_is_update(w_upd),
    .weight_storage_update_weight_interface_layer_index(u_l),
    .weight_storage_update_weight_interface_row_index(u_r),
    .weight_storage_update_weight_interface_dc_dw(u_d),
    .input_storage_is_write_interface_is_write(in_we),
    .input_storage_write_interface_write_layer_index(in_l),
    .input_storage_write_interface_write_row_index(in_r),
    .input_storage_write_interface_write_data(in_d),
    .label_storage_is_write_interface_is_write(lab_we),
    .label_storage_write_interface_write_layer_index(lab_l),
    .label_storage_write_interface_write_row_index(lab_r),
    .label_storage_write_interface_write_data(lab_d),
    .matrix_storage_locator_reset_interface_reset(loc_rst),
    .controller_use_z_interface_use_z(use_z),
    .activate_to_diff_register_out_x_interface_x(dut_x),
    .activate_to_diff_register_out_w_interface_w(dut_w),
    .activate_to_diff_register_out_z_interface_z(dut_z),
    .activate_to_diff_register_out_forward_interface_label(dut_label),
    .activate_to_diff_register_out_forward_interface_w_layer_index(dut_layer),
    .activate_to_diff_register_out_forward_interface_w_row_index(dut_row),
    .activate_to_diff_register_out_forward_interface_dense_type(dut_dense),
    .activate_to_diff_register_out_forward_interface_is_update(dut_is_update),
    .activate_to_diff_register_out_forward_interface_backprop_cost(dut_bp_cost),
    .activate_to_diff_register_out_cost_type_interface_cost_type(dut_cost)
  );

  // Q8.8 product per lane: (x*w) >>> 8, low 16 bits kept.
  function automatic logic [47:0] mdl_z(input logic [47:0] x, input logic [47:0] w);
    logic [47:0] r;
    int p;
    r = 48'd0;
    for (int i = 0; i < 3; i++) begin
      p = int'($signed(x[16*i +: 16])) * int'($signed(w[16*i +: 16]));
      p = p >>> 8;
      r[16*i +: 16] = p[15:0];
    end
    return r;
  endfunction

  function automatic logic [47:0] mdl_sub(input logic [47:0] a, input logic [47:0] b);
    logic [47:0] r;
    for (int i = 0; i < 3; i++) r[16*i +: 16] = a[16*i +: 16] - b[16*i +: 16];
    return r;
  endfunction

  function automatic logic [11:0] code_word(input logic [1:0] op, input logic [3:0] dense,
                                            input logic [1:0] cost, input logic [1:0] layer);
    return {op, dense, cost, 2'b00, layer};
  endfunction

  function automatic out_t observe();
    out_t o;
    o.x = dut_x; o.w = dut_w; o.z = dut_z; o.label = dut_label;
    o.layer = dut_layer; o.row = dut_row; o.dense = dut_dense;
    o.is_update = dut_is_update; o.bp_cost = dut_bp_cost; o.cost = dut_cost;
    return o;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr_code(input int line, input logic [11:0] d);
    code_we = 1'b1; code_line = 32'(line); code_data = d;
    step();
    code_we = 1'b0;
  endtask

  task automatic wr_rows(input int l, input int r, input logic [47:0] wd, input logic [47:0] id, input logic [47:0] ld);
    w_we = 1'b1; w_l = 32'(l); w_r = 32'(r); w_d = wd;
    in_we = 1'b1; in_l = 32'(l); in_r = 32'(r); in_d = id;
    lab_we = 1'b1; lab_l = 32'(l); lab_r = 32'(r); lab_d = ld;
    step();
    w_we = 1'b0; in_we = 1'b0; lab_we = 1'b0;
    m_weight[l][r] = wd; m_input[l][r] = id; m_label[l][r] = ld;
  endtask

  // Expected tuples for the first nrows rows of one compute instruction.
  task automatic push_instr(input logic [1:0] op, input logic [3:0] dense, input logic [1:0] cost,
                            input int layer, input int nrows);
    out_t e;
    logic uz;
    for (int r = 0; r < nrows; r++) begin
      uz = (op == OP_FWD) && (layer != 0);
      e.x = uz ? m_zbuf[r] : m_input[layer][r];
      e.w = m_weight[layer][r];
      e.z = mdl_z(e.x, e.w);
      e.label = m_label[layer][r];
      e.layer = 32'(layer);
      e.row = 32'(r);
      e.dense = dense;
      e.is_update = (op == OP_BP);
      e.bp_cost = (op == OP_BP) && (r == 3);
      e.cost = {6'd0, cost};
      sb.push_back(e);
      uz_q.push_back(uz);
      if (op == OP_FWD) m_zbuf[r] = e.z;
    end
  endtask

  // Locator restart, enable the controller and move IDLE -> FETCH.
  task automatic start_program();
    loc_rst = 1'b1;
    step();
    loc_rst = 1'b0;
    ctrl_en = 1'b1;
    step();
  endtask

  task automatic test_reset();
    out_t got;
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int l = 0; l < 4; l++)
      for (int r = 0; r < 4; r++)
        wr_rows(l, r, 48'({$urandom(), $urandom()}), 48'({$urandom(), $urandom()}), 48'({$urandom(), $urandom()}));
    wr_rows(0, 0, 48'h0200_0100_0080, 48'h0100_0300_0400, 48'h0000_0100_0000);
    reset = 1'b1; ctrl_en = 1'b1; code_en = 1'b1;
    step();
    reset = 1'b0; ctrl_en = 1'b0;
    got = observe();
    n_vec++;
    if (got !== '0) begin n_err++; $display("FAIL reset_outputs got=%h want=0", got); end
    n_vec++;
    if (use_z !== 1'b0) begin n_err++; $display("FAIL reset_use_z got=%b want=0", use_z); end
  endtask

  task automatic test_forward();
    out_t got, exp;
    logic uz;
    wr_code(0, code_word(OP_FWD, 4'd3, 2'd0, 2'd0));
    wr_code(1, code_word(OP_END, 4'd0, 2'd0, 2'd0));
    push_instr(OP_FWD, 4'd3, 2'd0, 0, 4);
    start_program();
    step();
    for (int r = 0; r < 4; r++) begin
      uz = uz_q.pop_front();
      n_vec++;
      if (use_z !== uz) begin n_err++; $display("FAIL fwd_use_z row%0d got=%b want=%b", r, use_z, uz); end
      step();
      got = observe(); exp = sb.pop_front();
      n_vec++;
      if (got !== exp) begin n_err++; $display("FAIL fwd_row%0d got=%h want=%h", r, got, exp); end
      if (r == 0) begin
        n_vec++;
        if (got.z !== 48'h0200_0300_0200 || got.row !== 32'd0 || got.dense !== 4'd3 || got.is_update !== 1'b0) begin
          n_err++; $display("FAIL fwd_row0_const got z=%h row=%0d dense=%0d upd=%b want z=020003000200 row=0 dense=3 upd=0",
                            got.z, got.row, got.dense, got.is_update);
        end
      end
    end
    step();
    step();
    got = observe();
    n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL fwd_done_hold got=%h want=%h", got, exp); end
    ctrl_en = 1'b0;
  endtask

  task automatic test_chain();
    out_t got, exp;
    logic uz;
    wr_code(0, code_word(OP_FWD, 4'd1, 2'd1, 2'd0));
    wr_code(1, code_word(OP_FWD, 4'd2, 2'd0, 2'd1));
    wr_code(2, code_word(OP_END, 4'd0, 2'd0, 2'd0));
    push_instr(OP_FWD, 4'd1, 2'd1, 0, 4);
    push_instr(OP_FWD, 4'd2, 2'd0, 1, 4);
    start_program();
    for (int i = 0; i < 2; i++) begin
      step();
      for (int r = 0; r < 4; r++) begin
        uz = uz_q.pop_front();
        n_vec++;
        if (use_z !== uz) begin n_err++; $display("FAIL chain_use_z L%0d row%0d got=%b want=%b", i, r, use_z, uz); end
        step();
        got = observe(); exp = sb.pop_front();
        n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL chain_L%0d_row%0d got=%h want=%h", i, r, got, exp); end
      end
    end
    step();
    ctrl_en = 1'b0;
  endtask

  task automatic test_backprop();
    out_t got, exp;
    logic uz;
    wr_code(0, code_word(OP_BP, 4'd5, 2'd2, 2'd1));
    wr_code(1, code_word(OP_END, 4'd0, 2'd0, 2'd0));
    push_instr(OP_BP, 4'd5, 2'd2, 1, 4);
    start_program();
    step();
    for (int r = 0; r < 4; r++) begin
      uz = uz_q.pop_front();
      n_vec++;
      if (use_z !== uz) begin n_err++; $display("FAIL bp_use_z row%0d got=%b want=%b", r, use_z, uz); end
      step();
      got = observe(); exp = sb.pop_front();
      n_vec++;
      if (got !== exp) begin n_err++; $display("FAIL bp_row%0d got=%h want=%h", r, got, exp); end
    end
    step();
    n_vec++;
    if (dut_is_update !== 1'b0 || dut_bp_cost !== 1'b0 || dut_cost !== 8'h02) begin
      n_err++; $display("FAIL bp_flags_clear got upd=%b bpc=%b cost=%h want upd=0 bpc=0 cost=02",
                        dut_is_update, dut_bp_cost, dut_cost);
    end
    ctrl_en = 1'b0;
  endtask

  task automatic test_update();
    out_t got, exp;
    w_upd = 1'b1; u_l = 32'd0; u_r = 32'd0; u_d = 48'h0100_0100_0100;
    step();
    w_upd = 1'b0;
    m_weight[0][0] = mdl_sub(m_weight[0][0], 48'h0100_0100_0100);
    // write and update to the same address in one cycle
    w_we = 1'b1; w_l = 32'd0; w_r = 32'd1; w_d = 48'h1234_1234_1234;
    w_upd = 1'b1; u_l = 32'd0; u_r = 32'd1; u_d = 48'h0001_0001_0001;
    step();
    w_we = 1'b0; w_upd = 1'b0;
    m_weight[0][1] = 48'h1234_1234_1234;
    wr_code(0, code_word(OP_FWD, 4'd4, 2'd3, 2'd0));
    wr_code(1, code_word(OP_END, 4'd0, 2'd0, 2'd0));
    push_instr(OP_FWD, 4'd4, 2'd3, 0, 4);
    start_program();
    step();
    for (int r = 0; r < 4; r++) begin
      void'(uz_q.pop_front());
      step();
      got = observe(); exp = sb.pop_front();
      n_vec++;
      if (got !== exp) begin n_err++; $display("FAIL upd_row%0d got=%h want=%h", r, got, exp); end
      if (r == 0) begin
        n_vec++;
        if (got.w !== 48'h0100_0000_ff80) begin n_err++; $display("FAIL upd_w00 got=%h want=01000000ff80", got.w); end
      end
      if (r == 1) begin
        n_vec++;
        if (got.w !== 48'h1234_1234_1234) begin n_err++; $display("FAIL upd_write_wins got=%h want=123412341234", got.w); end
      end
    end
    step();
    ctrl_en = 1'b0;
  endtask

  task automatic test_freeze_restart();
    out_t got, exp, held;
    logic uz;
    wr_code(0, code_word(OP_NOP, 4'd0, 2'd0, 2'd0));
    wr_code(1, code_word(OP_FWD, 4'd7, 2'd3, 2'd2));
    wr_code(2, code_word(OP_END, 4'd0, 2'd0, 2'd0));
    push_instr(OP_FWD, 4'd7, 2'd3, 2, 4);
    start_program();
    step();
    step();
    held = '0;
    for (int r = 0; r < 4; r++) begin
      if (r == 2) begin
        ctrl_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
          step();
          got = observe();
          n_vec++;
          if (got !== held || use_z !== 1'b1) begin
            n_err++; $display("FAIL freeze_hold cyc%0d got=%h use_z=%b want=%h use_z=1", k, got, use_z, held);
          end
        end
        ctrl_en = 1'b1;
      end
      uz = uz_q.pop_front();
      n_vec++;
      if (use_z !== uz) begin n_err++; $display("FAIL frz_use_z row%0d got=%b want=%b", r, use_z, uz); end
      step();
      got = observe(); exp = sb.pop_front(); held = exp;
      n_vec++;
      if (got !== exp) begin n_err++; $display("FAIL frz_row%0d got=%h want=%h", r, got, exp); end
    end
    step();
    // Second run is cut off by a locator reset in the middle of EXEC.
    push_instr(OP_FWD, 4'd7, 2'd3, 2, 2);
    push_instr(OP_FWD, 4'd7, 2'd3, 2, 4);
    start_program();
    step();
    step();
    for (int r = 0; r < 2; r++) begin
      void'(uz_q.pop_front());
      step();
      got = observe(); exp = sb.pop_front();
      n_vec++;
      if (got !== exp) begin n_err++; $display("FAIL abort_row%0d got=%h want=%h", r, got, exp); end
    end
    start_program();
    n_vec++;
    if (use_z !== 1'b0) begin n_err++; $display("FAIL restart_use_z got=%b want=0", use_z); end
    step();
    step();
    for (int r = 0; r < 4; r++) begin
      void'(uz_q.pop_front());
      step();
      got = observe(); exp = sb.pop_front();
      n_vec++;
      if (got !== exp) begin n_err++; $display("FAIL restart_row%0d got=%h want=%h", r, got, exp); end
    end
    step();
    ctrl_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; code_we = 1'b0; code_en = 1'b0; ctrl_en = 1'b0; loc_rst = 1'b0;
    code_line = 32'd0; code_data = 12'd0;
    w_we = 1'b0; w_upd = 1'b0; in_we = 1'b0; lab_we = 1'b0;
    w_l = 32'd0; w_r = 32'd0; u_l = 32'd0; u_r = 32'd0;
    in_l = 32'd0; in_r = 32'd0; lab_l = 32'd0; lab_r = 32'd0;
    w_d = 48'd0; u_d = 48'd0; in_d = 48'd0; lab_d = 48'd0;
    test_reset();
    test_forward();
    test_chain();
    test_backprop();
    test_update();
    test_freeze_restart();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
